gpio_bus_arbiter: RTL and testbench
===================================

Name: gpio_bus_arbiter

Overview:
Round-robin arbiter that shares the single register-bus port of one GPIO_Slave between N_REQ bus masters, for example the CPU and a pin-pattern sequencer.
- Latches one requester's command and issues it to the slave as a one-cycle strobe.
- Captures the slave's read data and error response, then returns them to the winner with a done pulse.
- Sits between the masters' bus decode and the GPIO_Slave instance.

Parameters:
N_REQ, 2, number of requesters (2..4)
ADDR_W, 32, bus address width
DATA_W, 32, bus data width

Ports:
i_Clk  in  1  system clock, all logic on rising edge
i_Rst  in  1  synchronous, active-high reset
i_Req  in  N_REQ  per-requester transaction request, level
i_WEnable  in  N_REQ  per-requester write strobe request
i_WAddr  in  N_REQ*ADDR_W  write addresses; requester k occupies slice k
i_WData  in  N_REQ*DATA_W  write data, sliced as i_WAddr
i_REnable  in  N_REQ  per-requester read request
i_RAddr  in  N_REQ*ADDR_W  read addresses, sliced
o_Gnt  out  N_REQ  one-hot; high from ISSUE through COMPLETE for the owner
o_Done  out  N_REQ  one-cycle completion pulse to the owner
o_RData  out  DATA_W  read data; valid in the o_Done cycle, held until the next completion
o_Err  out  1  error status for the completing transaction, valid with o_Done
o_Busy  out  1  high whenever state is not IDLE
o_S_WEnable  out  1  slave write strobe
o_S_WAddr  out  ADDR_W  slave write address
o_S_WData  out  DATA_W  slave write data
o_S_REnable  out  1  slave read strobe
o_S_RAddr  out  ADDR_W  slave read address
i_S_RData  in  DATA_W  slave read data, one cycle after o_S_REnable
i_S_Err  in  1  slave error, one cycle after the strobe

Behaviour:
- Reset values:
  - All outputs are 0, state IDLE, round-robin pointer 0.
  - The reset is synchronous, so a strobe in flight deasserts at the reset edge.
  - No o_Done is issued for an aborted transaction.
- State IDLE:
  - If i_Req is nonzero, select the first asserted index at or after the pointer, wrapping modulo N_REQ.
  - Register the winner index g and its WEnable/WAddr/WData/REnable/RAddr slices, then go to ISSUE.
- State ISSUE, exactly 1 cycle:
  - o_Gnt[g] is high; the slave strobes and addresses are driven from the latched command.
  - Write and read strobes may both be high in the same cycle.
  - Null command (neither enable set): no slave strobe is asserted, and COMPLETE reports o_Err=1 with o_RData unchanged.
  - Next state is COMPLETE.
- State COMPLETE, exactly 1 cycle:
  - Slave strobes are 0 and o_Gnt[g] stays high.
  - o_Done[g] pulses; o_Err is i_S_Err, or 1 for a null command.
  - If a read was issued, o_RData captures i_S_RData on this edge and is visible in the o_Done cycle.
  - Pointer is set to (g+1) mod N_REQ; next state is IDLE.
- Latency: request seen in IDLE at cycle t gives strobe at t+1 and o_Done at t+2. Minimum spacing between transactions is 3 cycles.
- Fairness: a requester holding i_Req continuously cannot win twice while another requester is pending.
- Requester inputs are sampled only at the arbitration edge. A later change to those inputs or to i_Req does not affect the in-flight transaction, and completion is still signalled.
- Single requester: it is re-granted every 3 cycles.
- Slave address values are passed through unmodified; the slave decodes them.

Decomposition:
- Shared package gpio_bus_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, COMPLETE=2'd2
  - the GPIO register offsets: DATA=0, DIR=1, REG2=2
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, winner index, valid.
  - Reusable by future shared peripherals.

Test Plan:
- Reset: i_Rst=1 for 2 cycles with i_Req=2'b11 -> all outputs 0, no strobe; the first grant goes to requester 0 two cycles after release.
- Single write: requester 0 writes WAddr=1, WData=0x0F -> o_S_WEnable=1 for one cycle with addr 1, data 0x0F; o_Done[0] one cycle later; o_Err=0.
- Read-back: after DIR=0x0F and DATA=0x55, requester 1 reads RAddr=0 -> o_Done[1] with o_RData matching the slave's data-register value; o_Gnt[0] stays 0.
- Contention: both requesters hold i_Req for 12 cycles -> grants alternate 0,1,0,1 with completions at t+2, t+5, t+8, t+11 and no back-to-back grant to the same requester.
- Null command and error: requester 0 requests with no enables -> no slave strobe, o_Done[0] with o_Err=1. A write to an unmapped address with i_S_Err=1 -> o_Err=1.
- Reset mid-operation: i_Rst asserted in the ISSUE cycle -> strobe low at the next edge, no o_Done, pointer back to 0.

Source files
------------

// File: rtl/gpio_bus_pkg.sv
// rtl/gpio_bus_pkg.sv - shared types and constants for the GPIO bus arbiter slice
package gpio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } arb_state_t;

  // Register offsets decoded by the GPIO slave; the arbiter passes addresses through untouched.
  localparam int unsigned REG_DATA = 0;
  localparam int unsigned REG_DIR  = 1;
  localparam int unsigned REG_REG2 = 2;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first request at or after the pointer
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int k;

  // Scan from the farthest offset down so the nearest request after ptr is written last and wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - round-robin share of one GPIO slave register port between N_REQ masters
module gpio_bus_arbiter
  import gpio_bus_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic [N_REQ-1:0]           i_Req,
  input  logic [N_REQ-1:0]           i_WEnable,
  input  logic [N_REQ*ADDR_W-1:0]    i_WAddr,
  input  logic [N_REQ*DATA_W-1:0]    i_WData,
  input  logic [N_REQ-1:0]           i_REnable,
  input  logic [N_REQ*ADDR_W-1:0]    i_RAddr,
  output logic [N_REQ-1:0]           o_Gnt,
  output logic [N_REQ-1:0]           o_Done,
  output logic [DATA_W-1:0]          o_RData,
  output logic                       o_Err,
  output logic                       o_Busy,
  output logic                       o_S_WEnable,
  output logic [ADDR_W-1:0]          o_S_WAddr,
  output logic [DATA_W-1:0]          o_S_WData,
  output logic                       o_S_REnable,
  output logic [ADDR_W-1:0]          o_S_RAddr,
  input  logic [DATA_W-1:0]          i_S_RData,
  input  logic                       i_S_Err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  own_idx;
  logic              we_q;
  logic              re_q;
  logic [DATA_W-1:0] rdata_q;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (i_Req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      own_idx     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rdata_q     <= '0;
      o_Gnt       <= '0;
      o_Done      <= '0;
      o_Busy      <= 1'b0;
      o_S_WEnable <= 1'b0;
      o_S_REnable <= 1'b0;
      o_S_WAddr   <= '0;
      o_S_WData   <= '0;
      o_S_RAddr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            own_idx     <= pick_idx;
            we_q        <= i_WEnable[pick_idx];
            re_q        <= i_REnable[pick_idx];
            o_S_WEnable <= i_WEnable[pick_idx];
            o_S_REnable <= i_REnable[pick_idx];
            o_S_WAddr   <= i_WAddr[pick_idx*ADDR_W +: ADDR_W];
            o_S_WData   <= i_WData[pick_idx*DATA_W +: DATA_W];
            o_S_RAddr   <= i_RAddr[pick_idx*ADDR_W +: ADDR_W];
            o_Gnt       <= pick_gnt;
            o_Busy      <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_S_WEnable <= 1'b0;
          o_S_REnable <= 1'b0;
          o_Done      <= o_Gnt;
          state       <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          if (re_q) rdata_q <= i_S_RData;
          o_Done <= '0;
          o_Gnt  <= '0;
          o_Busy <= 1'b0;
          ptr    <= IDX_W'(wrap_inc(int'(own_idx), N_REQ));
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The slave answers one cycle after the strobe, i.e. during COMPLETE, so the response is
  // forwarded straight through in the done cycle and the read data is then held in rdata_q.
  assign o_Err   = (state == ST_COMPLETE) && ((!we_q && !re_q) || i_S_Err);
  assign o_RData = (state == ST_COMPLETE && re_q) ? i_S_RData : rdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb/tb_gpio_bus_arbiter.sv - randomized bench for gpio_bus_arbiter against a transaction-level model
module tb_gpio_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, wen, ren;
  logic [N*AW-1:0] waddr, raddr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rdata;
  logic            err, busy;
  logic            s_wen, s_ren;
  logic [AW-1:0]   s_waddr, s_raddr;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic            s_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Req       (req),
    .i_WEnable   (wen),
    .i_WAddr     (waddr),
    .i_WData     (wdata),
    .i_REnable   (ren),
    .i_RAddr     (raddr),
    .o_Gnt       (gnt),
    .o_Done      (done),
    .o_RData     (rdata),
    .o_Err       (err),
    .o_Busy      (busy),
    .o_S_WEnable (s_wen),
    .o_S_WAddr   (s_waddr),
    .o_S_WData   (s_wdata),
    .o_S_REnable (s_ren),
    .o_S_RAddr   (s_raddr),
    .i_S_RData   (s_rdata),
    .i_S_Err     (s_err)
  );

  // GPIO slave stand-in: three registers, anything above offset 2 is unmapped and errors.
  logic [DW-1:0] slv_mem [0:2];
  always @(posedge clk) begin
    if (rst) begin
      s_rdata <= '0;
      s_err   <= 1'b0;
    end else begin
      s_rdata <= (s_ren && s_raddr < 3) ? slv_mem[s_raddr[1:0]] : '0;
      s_err   <= (s_wen && s_waddr > 2) || (s_ren && s_raddr > 2);
      if (s_wen && s_waddr < 3) slv_mem[s_waddr[1:0]] <= s_wdata;
    end
  end

  // Reference model: a transaction is in phase 1 (strobe) or 2 (done) after being won.
  int            ph, mptr, mg;
  bit            mwe, mre, merr;
  logic [AW-1:0] mwa, mra;
  logic [DW-1:0] mwd, mrd, pend;
  logic [DW-1:0] mmem [0:2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit found;
    if (rst) begin
      ph = 0; mptr = 0; mrd = '0;
    end else if (ph == 0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && req[(mptr + i) % N]) begin
          mg = (mptr + i) % N;
          found = 1;
        end
      end
      if (found) begin
        mwe = wen[mg];
        mre = ren[mg];
        mwa = waddr[mg*AW +: AW];
        mwd = wdata[mg*DW +: DW];
        mra = raddr[mg*AW +: AW];
        ph  = 1;
      end
    end else if (ph == 1) begin
      merr = (!mwe && !mre) || (mwe && mwa > 2) || (mre && mra > 2);
      pend = (mre && mra < 3) ? mmem[mra[1:0]] : '0;
      if (mwe && mwa < 3) mmem[mwa[1:0]] = mwd;
      ph = 2;
    end else begin
      if (mre) mrd = pend;
      mptr = (mg + 1) % N;
      ph   = 0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] own;
    own = (ph != 0) ? N'(1 << mg) : '0;
    check_eq("gnt",  gnt,  own);
    check_eq("done", done, (ph == 2) ? own : '0);
    check_eq("busy", busy, ph != 0);
    check_eq("s_wen", s_wen, ph == 1 && mwe);
    check_eq("s_ren", s_ren, ph == 1 && mre);
    check_eq("err",  err,  ph == 2 && merr);
    check_eq("rdata", rdata, (ph == 2 && mre) ? pend : mrd);
    if (ph == 1 && mwe) begin
      check_eq("s_waddr", s_waddr, mwa);
      check_eq("s_wdata", s_wdata, mwd);
    end
    if (ph == 1 && mre) check_eq("s_raddr", s_raddr, mra);
  endtask

  task automatic drive(input bit r, input logic [1:0] rq, input logic [1:0] w, input logic [1:0] rd,
                       input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] ra0,
                       input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] ra1);
    @(negedge clk);
    check_outputs();
    rst   = r;
    req   = rq;
    wen   = w;
    ren   = rd;
    waddr = {a1, a0};
    wdata = {d1, d0};
    raddr = {ra1, ra0};
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      slv_mem[i] = '0;
      mmem[i]    = '0;
    end
    ph = 0; mptr = 0; mg = 0; mwe = 0; mre = 0; merr = 0;
    mwa = '0; mra = '0; mwd = '0; mrd = '0; pend = '0;
    rst = 1'b1; req = 2'b11; wen = '0; ren = '0; waddr = '0; wdata = '0; raddr = '0;
    model_step();
    drive(1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    idle(4);
    // DIR=0x0F, DATA=0x55, then requester 1 reads DATA back
    drive(0, 2'b01, 2'b01, 2'b00, 1, 32'h0F, 0, 0, 0, 0);
    idle(3);
    drive(0, 2'b01, 2'b01, 2'b00, 0, 32'h55, 0, 0, 0, 0);
    idle(3);
    drive(0, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 12; i++)
      drive(0, 2'b11, 2'b11, 2'b00, 2, 32'hA0 + i, 0, 2, 32'hB0 + i, 0);
    idle(3);
    drive(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    idle(3);
    drive(0, 2'b01, 2'b01, 2'b00, 3, 32'hDEAD, 0, 0, 0, 0);
    idle(3);
    drive(0, 2'b01, 2'b01, 2'b00, 2, 32'h1234, 0, 0, 0, 0);
    drive(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 2);
    idle(3);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom, $urandom_range(0, 3));
    @(negedge clk);
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
